// File: rtl/pe_issuer_if.sv
// Stream bundle between upstream source, pe_issuer and the PE.
// slave = pe_issuer side, master = source/PE side.
interface pe_issuer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  pe_ack;

  modport master (
    output s_data,
    output s_valid,
    output pe_ack,
    input  s_ready,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  pe_ack,
    output s_ready,
    output o_data,
    output o_valid
  );
endinterface

// File: rtl/pe_issuer.sv
// PE issuer: FIFO-buffered work items handed to a PE, counted per frame.
// Ports: clk/rst_n, frame_start/frame_len/abort, bus (stream), busy/frame_done/issued_cnt/err_ack.
module pe_issuer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [CNT_WIDTH-1:0] frame_len,
  input  logic                 abort,
  pe_issuer_if.slave           bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] issued_cnt,
  output logic                 err_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         occ;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  acc_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic start_ok;
  logic last_pop;

  assign full  = (occ == OW'(DEPTH));
  assign empty = (occ == '0);

  // No pass-through: readiness ignores a same-cycle pop.
  assign bus.s_ready = (state_q == RUN) && !full
                       && (acc_cnt < len_q);
  // o_valid is from occupancy only, so a combinational
  // ack from the PE cannot form a loop.
  assign bus.o_valid = !empty;
  assign bus.o_data  = mem[rd_ptr];

  assign push     = bus.s_valid && bus.s_ready;
  assign pop      = bus.pe_ack && bus.o_valid;
  assign start_ok = (state_q == IDLE) && frame_start;
  assign last_pop = pop
                    && (issued_cnt == len_q - CNT_WIDTH'(1));

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_d = (frame_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_pop) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      len_q      <= '0;
      acc_cnt    <= '0;
      issued_cnt <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      acc_cnt    <= '0;
      issued_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (start_ok) begin
        len_q      <= frame_len;
        acc_cnt    <= '0;
        issued_cnt <= '0;
      end else begin
        if (push) acc_cnt    <= acc_cnt + 1'b1;
        if (pop)  issued_cnt <= issued_cnt + 1'b1;
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ack <= 1'b0;
    end else if (bus.pe_ack && !bus.o_valid) begin
      err_ack <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.s_data;
  end

endmodule

// File: tb/tb_pe_issuer.sv
// Self-checking bench for pe_issuer: queue model plus directed frames.
// Drives stimulus 1ns after rising edges, checks on falling edges.
module tb_pe_issuer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic [CW-1:0] frame_len;
  logic          abort;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] issued_cnt;
  logic          err_ack;
  logic          ack_auto;
  logic          ack_man;

  pe_issuer_if #(.DATA_WIDTH(DW)) bus ();

  assign bus.pe_ack = ack_auto ? bus.o_valid : ack_man;

  pe_issuer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .frame_len  (frame_len),
    .abort      (abort),
    .bus        (bus.slave),
    .busy       (busy),
    .frame_done (frame_done),
    .issued_cnt (issued_cnt),
    .err_ack    (err_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue + frame bookkeeping.
  logic [DW-1:0] mq[$];
  int            ms;
  int            mlen;
  int            macc;
  int            miss;
  bit            merr;

  logic [DW-1:0] popped[$];
  int            done_cnt;
  int            push_cnt;
  bit            pushed_n;

  initial begin
    bit e_ov;
    bit e_sr;
    bit mpush;
    bit mpop;
    ms = 0; mlen = 0; macc = 0; miss = 0; merr = 0;
    done_cnt = 0; push_cnt = 0; pushed_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        ms = 0; mlen = 0; macc = 0; miss = 0; merr = 0;
      end
      e_ov = (mq.size() != 0);
      e_sr = (ms == 1) && (mq.size() < DEPTH)
             && (macc < mlen);
      chk("busy", busy, (ms != 0));
      chk("frame_done", frame_done, (ms == 2));
      chk("s_ready", bus.s_ready, e_sr);
      chk("o_valid", bus.o_valid, e_ov);
      chk("issued_cnt", issued_cnt, miss);
      chk("err_ack", err_ack, merr);
      if (e_ov) chk("o_data", bus.o_data, mq[0]);
      mpush = bus.s_valid && e_sr;
      mpop  = bus.pe_ack && e_ov;
      pushed_n = rst_n && !abort && mpush;
      if (rst_n) begin
        if (frame_done) done_cnt++;
        if (bus.pe_ack && !e_ov) merr = 1;
        if (abort) begin
          mq.delete();
          ms = 0; macc = 0; miss = 0;
        end else begin
          if (mpop) begin
            popped.push_back(mq[0]);
            void'(mq.pop_front());
            miss++;
          end
          if (mpush) begin
            mq.push_back(bus.s_data);
            macc++;
            push_cnt++;
          end
          case (ms)
            0: if (frame_start) begin
              mlen = int'(frame_len);
              macc = 0;
              miss = 0;
              ms   = (mlen == 0) ? 2 : 1;
            end
            1: if (mpop && miss == mlen) ms = 2;
            default: ms = 0;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (pushed_n) bus.s_data = bus.s_data + 1;
  endtask

  task automatic start(int len);
    frame_len   = CW'(len);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(string name);
    bit found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1;
        break;
      end
      tick();
    end
    chk({name, "_done_seen"}, found, 1);
  endtask

  task automatic chk_seq(string name, logic [DW-1:0] base,
                         int n);
    chk({name, "_count"}, popped.size(), n);
    for (int i = 0; i < n && i < popped.size(); i++) begin
      chk({name, "_item"}, popped[i], base + DW'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    frame_len   = '0;
    abort       = 1'b0;
    ack_auto    = 1'b0;
    ack_man     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_err", err_ack, 0);
    chk("rst_done", frame_done, 0);
    tick();

    // Frame of 3, back-to-back pushes, PE acks as items appear.
    done_cnt = 0;
    popped.delete();
    ack_auto = 1'b1;
    start(3);
    bus.s_data  = 32'hA0;
    bus.s_valid = 1'b1;
    repeat (3) tick();
    bus.s_valid = 1'b0;
    wait_done("t1");
    chk("t1_issued_at_done", issued_cnt, 3);
    chk("t1_busy_at_done", busy, 1);
    tick();
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_pulses", done_cnt, 1);
    chk_seq("t1", 32'hA0, 3);
    tick();

    // Fill the FIFO with no acks, then drain with pointer wrap.
    done_cnt = 0;
    push_cnt = 0;
    popped.delete();
    ack_auto = 1'b0;
    start(6);
    bus.s_data  = 32'h100;
    bus.s_valid = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t2_full_s_ready", bus.s_ready, 0);
    chk("t2_full_o_valid", bus.o_valid, 1);
    chk("t2_head_held", bus.o_data, 32'h100);
    chk("t2_pushes", push_cnt, 4);
    tick();
    ack_auto = 1'b1;
    wait_done("t2");
    chk("t2_issued_at_done", issued_cnt, 6);
    bus.s_valid = 1'b0;
    tick();
    chk_seq("t2", 32'h100, 6);
    chk("t2_done_pulses", done_cnt, 1);

    // Upstream offers more than frame_len.
    push_cnt = 0;
    popped.delete();
    ack_auto = 1'b0;
    start(2);
    bus.s_data  = 32'h200;
    bus.s_valid = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("t3_s_ready", bus.s_ready, 0);
    chk("t3_pushes", push_cnt, 2);
    tick();
    ack_auto = 1'b1;
    wait_done("t3");
    bus.s_valid = 1'b0;
    tick();
    chk_seq("t3", 32'h200, 2);

    // Zero-length frame; frame_start during RUN is ignored.
    done_cnt = 0;
    start(0);
    @(negedge clk);
    chk("t4_zero_done", frame_done, 1);
    chk("t4_zero_s_ready", bus.s_ready, 0);
    chk("t4_zero_o_valid", bus.o_valid, 0);
    tick();
    @(negedge clk);
    chk("t4_zero_busy_after", busy, 0);
    tick();
    popped.delete();
    start(2);
    frame_len   = CW'(5);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bus.s_data  = 32'h300;
    bus.s_valid = 1'b1;
    repeat (2) tick();
    bus.s_valid = 1'b0;
    wait_done("t4");
    chk("t4_issued_at_done", issued_cnt, 2);
    tick();
    tick();
    chk("t4_done_pulses", done_cnt, 2);
    chk_seq("t4", 32'h300, 2);

    // Abort with two items buffered, then a frame of one.
    done_cnt = 0;
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    start(4);
    bus.s_data  = 32'h400;
    bus.s_valid = 1'b1;
    repeat (2) tick();
    bus.s_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("t5_o_valid", bus.o_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_issued", issued_cnt, 0);
    chk("t5_s_ready", bus.s_ready, 0);
    tick();
    chk("t5_no_done", done_cnt, 0);
    popped.delete();
    start(1);
    bus.s_data  = 32'h500;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    ack_auto = 1'b1;
    wait_done("t5");
    tick();
    tick();
    chk("t5_done_pulses", done_cnt, 1);
    chk_seq("t5", 32'h500, 1);

    // Spurious ack, then async reset mid-frame.
    ack_auto = 1'b0;
    ack_man  = 1'b1;
    tick();
    ack_man = 1'b0;
    @(negedge clk);
    chk("t6_err_set", err_ack, 1);
    repeat (3) tick();
    start(3);
    bus.s_data  = 32'h600;
    bus.s_valid = 1'b1;
    repeat (2) tick();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("t6_err_sticky", err_ack, 1);
    chk("t6_o_valid", bus.o_valid, 1);
    chk("t6_issued", issued_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_o_valid", bus.o_valid, 0);
    chk("t6_rst_s_ready", bus.s_ready, 0);
    chk("t6_rst_issued", issued_cnt, 0);
    chk("t6_rst_err", err_ack, 0);
    chk("t6_rst_done", frame_done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_o_valid", bus.o_valid, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
